// File: rtl/serdes_pkg.sv
// Types and constants shared by the serial link receiver and its matching transmitter.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Bit-order encoding carried on lsb_first.
    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out bundle: the serial link plus the word handshake and status.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic             lsb_first;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             clr_err;

    // Driver of the serial link and consumer of words.
    modport master (
        output ser_in, ser_valid, frame_start, lsb_first, data_ready, clr_err,
        input  data_out, data_valid, busy, frame_err, overrun
    );

    // The receiver itself.
    modport slave (
        input  ser_in, ser_valid, frame_start, lsb_first, data_ready, clr_err,
        output data_out, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Deserializes WIDTH-bit frames (MSB- or LSB-first per frame) into a one-entry
// output buffer with valid/ready handshake, abort detection and sticky overrun.
module serial_word_receiver
    import serdes_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_receiver_if.slave  rx
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic             order_reg, order_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;
    logic             ovr_reg, ovr_next;

    logic             start_bit;
    logic [WIDTH-1:0] shift_src;
    logic             shift_order;
    logic [WIDTH-1:0] msb_shift, lsb_shift, shifted;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_bit;
    logic             complete;
    logic             buf_free;
    logic             ovr_set;

    // A start bit always begins from an empty register, whether it opens a
    // frame from IDLE or aborts one in RECV.
    assign start_bit   = rx.ser_valid && rx.frame_start;
    assign shift_src   = start_bit ? '0 : sh_reg;
    assign shift_order = start_bit ? rx.lsb_first : order_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_msb_in
                assign msb_shift[gi] = rx.ser_in;
            end else begin : g_msb_mv
                assign msb_shift[gi] = shift_src[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_lsb_in
                assign lsb_shift[gi] = rx.ser_in;
            end else begin : g_lsb_mv
                assign lsb_shift[gi] = shift_src[gi+1];
            end
        end
    endgenerate

    assign shifted  = (shift_order == ORDER_LSB_FIRST) ? lsb_shift : msb_shift;
    assign cnt_inc  = cnt_reg + CNT_ONE;
    assign last_bit = (cnt_inc == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_bit) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (rx.ser_valid && !rx.frame_start && last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_next   = cnt_reg;
        sh_next    = sh_reg;
        order_next = order_reg;
        ferr_next  = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_bit) begin
                    sh_next    = shifted;
                    cnt_next   = CNT_ONE;
                    order_next = rx.lsb_first;
                end
            end
            RECV: begin
                if (start_bit) begin
                    // Restart wins even on what would have been the completing bit.
                    sh_next    = shifted;
                    cnt_next   = CNT_ONE;
                    order_next = rx.lsb_first;
                    ferr_next  = 1'b1;
                end else if (rx.ser_valid) begin
                    sh_next  = shifted;
                    cnt_next = cnt_inc;
                    if (last_bit) begin
                        complete = 1'b1;
                        cnt_next = '0;
                    end
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase

        buf_free   = !valid_reg || rx.data_ready;
        data_next  = data_reg;
        valid_next = valid_reg;
        ovr_set    = 1'b0;
        if (complete) begin
            if (buf_free) begin
                data_next  = shifted;
                valid_next = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (rx.data_ready && valid_reg) begin
            valid_next = 1'b0;
        end

        ovr_next = ovr_set || (ovr_reg && !rx.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            sh_reg    <= '0;
            order_reg <= ORDER_MSB_FIRST;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
            order_reg <= order_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign rx.data_out   = data_reg;
    assign rx.data_valid = valid_reg;
    assign rx.busy       = (state_reg == RECV);
    assign rx.frame_err  = ferr_reg;
    assign rx.overrun    = ovr_reg;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: a vector table of whole frames plus
// hand-written sequences for overrun, simultaneous consume, abort and reset.
module tb_serial_word_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    serial_word_receiver_if #(.WIDTH(4)) bus ();

    serial_word_receiver #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lsb;
        logic [3:0] bits;   // bits[3] is sent first
        int         gap;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs, input logic lsb);
        bus.ser_in      = b;
        bus.ser_valid   = 1'b1;
        bus.frame_start = fs;
        bus.lsb_first   = lsb;
        tick();
        bus.ser_valid   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic lsb, input logic [3:0] bits, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[3-i], (i == 0), lsb);
            if (i < 3) begin
                check("busy_mid", 32'(bus.busy), 32'd1);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", 32'(bus.busy), 32'd1);
                end
            end
        end
    endtask

    task automatic consume();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check("consumed", 32'(bus.data_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{lsb: 1'b0, bits: 4'b1011, gap: 0, exp: 4'hB};
        vecs[1] = '{lsb: 1'b1, bits: 4'b1011, gap: 2, exp: 4'hD};
        vecs[2] = '{lsb: 1'b0, bits: 4'b0110, gap: 1, exp: 4'h6};
        vecs[3] = '{lsb: 1'b1, bits: 4'b0010, gap: 0, exp: 4'h4};
        vecs[4] = '{lsb: 1'b1, bits: 4'b1000, gap: 3, exp: 4'h1};

        bus.ser_in = 1'b0; bus.ser_valid = 1'b0; bus.frame_start = 1'b0;
        bus.lsb_first = 1'b0; bus.data_ready = 1'b0; bus.clr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_data",  32'(bus.data_out),   32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_ferr",  32'(bus.frame_err),  32'd0);
        check("rst_ovr",   32'(bus.overrun),    32'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].lsb, vecs[v].bits, vecs[v].gap);
            $display("vec %0d: lsb=%0b bits=%b gap=%0d -> data_out=%h valid=%0b",
                     v, vecs[v].lsb, vecs[v].bits, vecs[v].gap, bus.data_out, bus.data_valid);
            check("vec_data",  32'(bus.data_out),   32'(vecs[v].exp));
            check("vec_valid", 32'(bus.data_valid), 32'd1);
            check("vec_busy",  32'(bus.busy),       32'd0);
            check("vec_ovr",   32'(bus.overrun),    32'd0);
            consume();
        end

        // Overrun: second word dropped while first waits
        send_frame(1'b0, 4'hA, 0);
        check("ovr_first", 32'(bus.data_out), 32'hA);
        send_frame(1'b0, 4'h5, 0);
        $display("overrun: data_out=%h overrun=%0b", bus.data_out, bus.overrun);
        check("ovr_keep",  32'(bus.data_out),   32'hA);
        check("ovr_valid", 32'(bus.data_valid), 32'd1);
        check("ovr_flag",  32'(bus.overrun),    32'd1);
        tick();
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 32'd0);
        consume();

        // Consume and complete on the same edge
        send_frame(1'b0, 4'h3, 0);
        check("sim_first", 32'(bus.data_out), 32'h3);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("sim_hold", 32'(bus.data_out), 32'h3);
        bus.data_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        $display("simultaneous: data_out=%h valid=%0b overrun=%0b", bus.data_out, bus.data_valid, bus.overrun);
        check("sim_data",  32'(bus.data_out),   32'hC);
        check("sim_valid", 32'(bus.data_valid), 32'd1);
        check("sim_ovr",   32'(bus.overrun),    32'd0);
        tick();
        bus.data_ready = 1'b0;
        check("sim_cons", 32'(bus.data_valid), 32'd0);

        // Abort after two bits
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check("ab_ferr0", 32'(bus.frame_err), 32'd0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("ab_ferr1", 32'(bus.frame_err), 32'd1);
        check("ab_busy",  32'(bus.busy),      32'd1);
        send_bit(1'b1, 1'b0, 1'b0);
        check("ab_ferr2", 32'(bus.frame_err), 32'd0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        $display("abort: data_out=%h valid=%0b", bus.data_out, bus.data_valid);
        check("ab_data",  32'(bus.data_out),   32'h6);
        check("ab_valid", 32'(bus.data_valid), 32'd1);
        consume();

        // frame_start on what would be the completing bit is an abort
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("ab4_ferr",  32'(bus.frame_err),  32'd1);
        check("ab4_valid", 32'(bus.data_valid), 32'd0);
        check("ab4_busy",  32'(bus.busy),       32'd1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        $display("abort-on-last: data_out=%h valid=%0b", bus.data_out, bus.data_valid);
        check("ab4_data", 32'(bus.data_out), 32'hB);
        consume();

        // Back-to-back frames with data_ready held high
        bus.data_ready = 1'b1;
        send_frame(1'b0, 4'h5, 0);
        check("b2b_d1", 32'(bus.data_out), 32'h5);
        send_frame(1'b1, 4'h5, 0);
        $display("back-to-back: data_out=%h overrun=%0b", bus.data_out, bus.overrun);
        check("b2b_d2",  32'(bus.data_out),   32'hA);
        check("b2b_v2",  32'(bus.data_valid), 32'd1);
        check("b2b_ovr", 32'(bus.overrun),    32'd0);
        tick();
        bus.data_ready = 1'b0;

        // Reset mid-frame with a word buffered
        send_frame(1'b0, 4'hA, 0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(bus.data_valid), 32'd0);
        check("mr_data",  32'(bus.data_out),   32'h0);
        check("mr_busy",  32'(bus.busy),       32'd0);
        send_frame(1'b0, 4'h1, 0);
        $display("reset mid-frame: data_out=%h valid=%0b", bus.data_out, bus.data_valid);
        check("mr_new",   32'(bus.data_out),   32'h1);
        check("mr_nv",    32'(bus.data_valid), 32'd1);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Deserializing receiver for the serial stream produced by the universal shift register's MSB/LSB serial outputs. It samples one bit per `ser_valid` strobe and assembles `WIDTH` bits into a parallel word. Bit order is MSB-first or LSB-first, selected per frame. The completed word is held in an output buffer with a valid/ready handshake. It sits on the far end of the serial link from the shift-register transmitter and feeds parallel consumers.

## Interface
- `WIDTH`, 4: bits per word; legal values are WIDTH ≥ 2.
- `CNT_W`, $clog2(WIDTH+1): width of the bit counter (derived).

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `ser_in`, in, 1: serial data bit.
- `ser_valid`, in, 1: `ser_in` is valid this cycle.
- `frame_start`, in, 1: marks the first bit of a frame; only meaningful with `ser_valid`.
- `lsb_first`, in, 1: bit order, sampled with the first bit. 0 = MSB-first, from a left-shifting transmitter. 1 = LSB-first, from a right-shifting transmitter.
- `data_out`, out, WIDTH: received word.
- `data_valid`, out, 1: `data_out` holds an unconsumed word.
- `data_ready`, in, 1: consumer accepts `data_out`.
- `busy`, out, 1: a frame is in progress (state RECV).
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted by a new `frame_start`.
- `overrun`, out, 1: sticky; a completed word was dropped.
- `clr_err`, in, 1: clears `overrun`.

## Operation
- FSM states:
  - **IDLE:** on `ser_valid && frame_start`, capture the first bit, latch `lsb_first` into `order_q`, set `cnt=1`, go to RECV. A `ser_valid` without `frame_start` is ignored.
  - **RECV:** each `ser_valid` shifts in one bit and sets `cnt++`. Cycles without `ser_valid` hold all state; gaps are unbounded.
- Shift rule:
  - MSB-first: `sh <= {sh[WIDTH-2:0], ser_in}`.
  - LSB-first: `sh <= {ser_in, sh[WIDTH-1:1]}`.
  - After WIDTH bits, the first-received bit is at `sh[WIDTH-1]` for MSB-first and at `sh[0]` for LSB-first.
- Completion: the bit that brings `cnt` to WIDTH completes the word. The assembled value, including that bit, goes to the output buffer and the FSM returns to IDLE.
- Output buffer (1 entry, independent of the shift register, so the next frame can be received while a word waits):
  - The buffer is free when `!data_valid || data_ready`.
  - Complete and free: load `data_out`, set `data_valid=1`.
  - Complete and not free: drop the new word, keep the old one, set `overrun=1`.
  - `data_ready && data_valid` with no completion: set `data_valid=0`; `data_out` holds its last value.
- `frame_start` with `ser_valid` while in RECV (before completion): pulse `frame_err` and discard the partial word. That bit is treated as the first bit of a new frame (`cnt=1`, `lsb_first` re-latched), and the FSM stays in RECV.
- A `frame_start` on the completing bit itself also counts as an abort, because the frame is still in RECV when that bit arrives.
- `clr_err`: clears `overrun` next cycle. If an overrun event occurs in the same cycle, set wins.
- `rst` has priority over everything. Mid-frame it discards the partial word and drops any buffered word.
- Reset values: state IDLE, `cnt=0`, `data_out=0`, `data_valid=0`, `busy=0`, `frame_err=0`, `overrun=0`.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Latency: if the last bit is sampled at edge N, `data_valid` is high and `data_out` is stable after edge N.
- A word is consumed at the first edge where `data_valid && data_ready`.
- Back-to-back frames with no gap (WIDTH cycles each) complete one word every WIDTH cycles. With `data_ready` held high there is no overrun.
- `busy` goes high after the edge that samples a first bit, and low after the edge that completes the word.
- `frame_err` is high for exactly one cycle after the aborting edge.

## Structure
- Shared package `serdes_pkg`:
  - `rx_state_t` enum (IDLE, RECV).
  - Bit-order constants `ORDER_MSB_FIRST=1'b0`, `ORDER_LSB_FIRST=1'b1`, for reuse by the transmitter side.
- Single module, no sub-modules. The FSM, shift register, counter and output buffer fit cleanly in one block.

## Test plan
- **Reset, then MSB-first frame:** after reset, check all outputs are 0. Send `lsb_first=0`, bits 1,0,1,1 with `frame_start` on the first bit → `data_out=4'hB`, `data_valid=1` one edge after the 4th bit.
- **LSB-first frame with gaps:** `lsb_first=1`, bits 1,0,1,1 with 2-cycle `ser_valid` gaps between bits → `data_out=4'hD`; `busy` stays high through the gaps.
- **Overrun:** `data_ready=0`; receive 4'hA, then 4'h5 → `data_out` stays 4'hA and `overrun=1`. Pulse `clr_err` → `overrun=0`.
- **Simultaneous consume and complete:** 4'h3 is buffered; assert `data_ready` on the same edge the next word 4'hC completes → `data_out=4'hC`, `data_valid=1`, `overrun=0`.
- **Abort:** after 2 bits (1,1), assert `frame_start` with bit 0, then send 1,1,0 → `frame_err` pulses once, and the final `data_out=4'h6` (MSB-first 0,1,1,0).
- **Reset mid-frame:** `rst` after 3 bits, then a clean frame 0,0,0,1 → `data_out=4'h1` with no stale bits; `data_valid` was 0 after the reset.
